// File: rtl/wb_slave_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : wb_slave_mux                                                   |
// | Purpose : Wishbone pipelined interconnect, one master to NUM_SLAVES      |
// |           slaves. The slave is chosen by the address field               |
// |           m_addr_i[SEL_MSB:SEL_LSB]. The block tracks outstanding        |
// |           requests and only switches slaves once all of them are         |
// |           answered. An internal error slave answers decode misses, and   |
// |           a watchdog forces an error ack when a response never arrives.  |
// | Ports   : clk_i/rst_i          clock, asynchronous active-high reset     |
// |           m_*                  master-side Wishbone pipelined port       |
// |           s_addr/data/sel/we_o broadcast to every slave                  |
// |           s_stb_o              one-hot per-slave strobe                   |
// |           s_data/ack/stall_i   per-slave returns, slave k at bit/lane k  |
// |           timeout_o            sticky watchdog flag                       |
// |           timeout_clr_i        clears timeout_o                           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module wb_slave_mux #(
    parameter int          NUM_SLAVES      = 4,
    parameter int          SEL_MSB         = 31,
    parameter int          SEL_LSB         = 30,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          TIMEOUT_CYCLES  = 1024,
    parameter logic [31:0] ERR_DATA        = 32'hBADADD00
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              m_addr_i,
    input  logic [31:0]              m_data_i,
    input  logic [3:0]               m_sel_i,
    input  logic                     m_we_i,
    input  logic                     m_stb_i,
    input  logic                     m_cyc_i,
    output logic [31:0]              m_data_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_stall_o,
    output logic [31:0]              s_addr_o,
    output logic [31:0]              s_data_o,
    output logic [3:0]               s_sel_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [32*NUM_SLAVES-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_stall_i,
    output logic                     timeout_o,
    input  logic                     timeout_clr_i
);

    localparam int c_IDX_W = SEL_MSB - SEL_LSB + 1;
    // Slave-index width must also hold NUM_SLAVES, the error slave.
    localparam int c_SEL_W = $clog2(NUM_SLAVES + 1);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_SEL_W-1:0] c_ERR_SLV = c_SEL_W'(NUM_SLAVES);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

    logic [c_SEL_W-1:0] r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMR_W-1:0] r_tmr;
    logic               r_timeout;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_hit;
    logic [c_SEL_W-1:0] w_tgt;
    logic               w_busy;
    logic               w_block;
    logic               w_req;
    logic               w_stall;
    logic               w_accept;
    logic               w_force;
    logic               w_tgt_stall;
    logic               w_sel_ack;
    logic [31:0]        w_sel_data;

    // Broadcast buses pass straight through, even during reset.
    assign s_addr_o  = m_addr_i;
    assign s_data_o  = m_data_i;
    assign s_sel_o   = m_sel_i;
    assign s_we_o    = m_we_i;
    assign timeout_o = r_timeout;

    // Decode; every out-of-range index collapses onto the error slave.
    assign w_idx  = m_addr_i[SEL_MSB:SEL_LSB];
    assign w_hit  = (32'(w_idx) < 32'(NUM_SLAVES));
    assign w_tgt  = w_hit ? c_SEL_W'(w_idx) : c_ERR_SLV;
    assign w_busy = (r_cnt != '0);

    // Hold a new request while responses from a different slave are still
    // pending, so responses can never be reordered across slaves.
    assign w_block = (w_busy && (w_tgt != r_sel)) || (r_cnt == c_MAX_CNT);

    // Qualifying with rst_i keeps stall/strobe low during reset regardless of
    // what the master and slaves drive.
    assign w_req     = m_cyc_i & m_stb_i & ~rst_i;
    assign w_stall   = w_req & (w_block | (w_hit & w_tgt_stall));
    assign m_stall_o = w_stall;
    assign w_accept  = w_req & ~w_stall;

    always_comb begin
        w_tgt_stall = 1'b0;
        w_sel_ack   = 1'b0;
        w_sel_data  = '0;
        s_stb_o     = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_tgt == c_SEL_W'(k)) begin
                w_tgt_stall = s_stall_i[k];
                s_stb_o[k]  = w_req & ~w_block & w_hit;
            end
            if (r_sel == c_SEL_W'(k)) begin
                w_sel_ack  = s_ack_i[k];
                w_sel_data = s_data_i[32*k +: 32];
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            assign w_force = w_busy && (r_tmr == c_TMR_W'(TIMEOUT_CYCLES));
        end else begin : g_no_wdog
            assign w_force = 1'b0;
        end
    endgenerate

    // Response path: pure function of registered state and slave returns.
    // A forced timeout ack takes precedence over (and absorbs) a late real ack.
    always_comb begin
        m_ack_o  = 1'b0;
        m_err_o  = 1'b0;
        m_data_o = '0;
        if (w_force) begin
            m_ack_o  = 1'b1;
            m_err_o  = 1'b1;
            m_data_o = ERR_DATA;
        end else if (w_busy) begin
            if (r_sel == c_ERR_SLV) begin
                m_ack_o  = 1'b1;
                m_err_o  = 1'b1;
                m_data_o = ERR_DATA;
            end else begin
                m_ack_o  = w_sel_ack;
                m_data_o = w_sel_data;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_tmr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel <= w_tgt;
            end
            if (w_busy && !m_cyc_i) begin
                // Master abandoned the cycle: forget everything outstanding.
                r_cnt <= '0;
                r_tmr <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(w_accept) - c_CNT_W'(m_ack_o);
                if (!w_busy || m_ack_o) begin
                    r_tmr <= '0;
                end else begin
                    r_tmr <= r_tmr + c_TMR_W'(1);
                end
            end
            if (w_force) begin
                r_timeout <= 1'b1;
            end else if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_wb_slave_mux                                                |
// | Purpose : Self-checking bench for wb_slave_mux (3 slaves, 4 outstanding, |
// |           16-cycle watchdog). Random traffic is compared every cycle     |
// |           against a queue-based transaction model, followed by directed  |
// |           hit, miss, timeout, abort and reset scenarios.                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_wb_slave_mux;

    localparam int          NS   = 3;
    localparam int          MAXO = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] ERRD = 32'hBADADD00;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [31:0]    m_addr_i, m_data_i, m_data_o, s_addr_o, s_data_o;
    logic [3:0]     m_sel_i, s_sel_o;
    logic           m_we_i, m_stb_i, m_cyc_i, m_ack_o, m_err_o, m_stall_o, s_we_o;
    logic [NS-1:0]  s_stb_o, s_ack_i, s_stall_i;
    logic [32*NS-1:0] s_data_i;
    logic           timeout_o, timeout_clr_i;

    always #5 clk_i = ~clk_i;

    wb_slave_mux #(
        .NUM_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(30),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRD)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
        .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i),
        .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Transaction model: one queue entry per accepted, unanswered request.
    int pend[$];
    int last_tgt = 0;
    int wait_cnt = 0;
    bit to_flag  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit cyc, input bit stb, input logic [31:0] addr,
                          input logic [NS-1:0] ack, input logic [NS-1:0] stall, input bit clr);
        m_cyc_i       = cyc;
        m_stb_i       = stb;
        m_addr_i      = addr;
        m_data_i      = $urandom;
        m_sel_i       = 4'($urandom);
        m_we_i        = 1'($urandom);
        s_ack_i       = ack;
        s_stall_i     = stall;
        s_data_i      = {$urandom, $urandom, $urandom};
        timeout_clr_i = clr;
    endtask

    task automatic rand_in(input int ack_pct);
        logic [NS-1:0] a, s;
        for (int k = 0; k < NS; k++) begin
            a[k] = ($urandom_range(99) < ack_pct);
            s[k] = ($urandom_range(99) < 20);
        end
        set_in($urandom_range(99) < 95, $urandom_range(99) < 60, $urandom, a, s,
               $urandom_range(99) < 5);
    endtask

    task automatic cycle_pre();
        #3;
    endtask

    // Compare every output against the model, then advance the model across
    // the next rising edge. Entered at posedge+4, leaves at posedge+1.
    task automatic cycle_post();
        int idx, tgt;
        bit busy, blocked, forced, acc;
        logic e_stall, e_ack, e_err;
        logic [31:0] e_data;
        logic [NS-1:0] e_stb;
        idx     = int'(m_addr_i[31:30]);
        tgt     = (idx < NS) ? idx : NS;
        busy    = (pend.size() != 0);
        blocked = (busy && tgt != last_tgt) || (pend.size() == MAXO);
        e_stall = m_cyc_i && m_stb_i && (blocked || (tgt < NS && s_stall_i[tgt]));
        e_stb   = '0;
        if (m_cyc_i && m_stb_i && !blocked && tgt < NS) e_stb[tgt] = 1'b1;
        forced  = busy && (wait_cnt == TO);
        if (forced || (busy && last_tgt == NS)) begin
            e_ack = 1'b1; e_err = 1'b1; e_data = ERRD;
        end else if (busy) begin
            e_ack = s_ack_i[last_tgt]; e_err = 1'b0; e_data = s_data_i[32*last_tgt +: 32];
        end else begin
            e_ack = 1'b0; e_err = 1'b0; e_data = '0;
        end
        chk("stall", 32'(m_stall_o), 32'(e_stall));
        chk("stb",   32'(s_stb_o),   32'(e_stb));
        chk("ack",   32'(m_ack_o),   32'(e_ack));
        chk("err",   32'(m_err_o),   32'(e_err));
        chk("data",  m_data_o,       e_data);
        chk("tmo",   32'(timeout_o), 32'(to_flag));
        chk("bcast", {s_addr_o[31:1] ^ s_data_o[31:1], s_we_o},
                     {m_addr_i[31:1] ^ m_data_i[31:1], m_we_i});
        acc = m_cyc_i && m_stb_i && !e_stall;
        @(posedge clk_i);
        if (busy && !m_cyc_i) begin
            pend.delete();
            wait_cnt = 0;
        end else begin
            if (e_ack) void'(pend.pop_front());
            if (acc) pend.push_back(tgt);
            wait_cnt = (!busy || e_ack) ? 0 : wait_cnt + 1;
        end
        if (acc) last_tgt = tgt;
        if (forced) to_flag = 1'b1;
        else if (timeout_clr_i) to_flag = 1'b0;
        #1;
    endtask

    task automatic cycle();
        cycle_pre();
        cycle_post();
    endtask

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock.
    task automatic async_reset();
        set_in(1, 1, 32'h4000_0000, '1, '1, 0);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_ack",   32'(m_ack_o),   32'd0);
        chk("arst_err",   32'(m_err_o),   32'd0);
        chk("arst_data",  m_data_o,       32'd0);
        chk("arst_stall", 32'(m_stall_o), 32'd0);
        chk("arst_stb",   32'(s_stb_o),   32'd0);
        chk("arst_addr",  s_addr_o,       32'h4000_0000);
        pend.delete();
        last_tgt = 0;
        wait_cnt = 0;
        to_flag  = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        set_in(1, 1, 32'h0000_0000, '1, '1, 0);
        #3;
        chk("rst_ack",   32'(m_ack_o),   32'd0);
        chk("rst_stall", 32'(m_stall_o), 32'd0);
        chk("rst_stb",   32'(s_stb_o),   32'd0);
        chk("rst_tmo",   32'(timeout_o), 32'd0);
        chk("rst_data",  m_data_o,       32'd0);
        set_in(0, 0, 0, '0, '0, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        repeat (1500) begin rand_in(30); cycle(); end
        repeat (1500) begin rand_in(2);  cycle(); end

        // Drain: abort anything outstanding and clear the sticky flag.
        repeat (2) begin set_in(0, 0, 0, '0, '0, 1); cycle(); end

        // Hit on slave 1, answered two cycles after the strobe.
        set_in(1, 1, 32'h4000_0010, '0, '0, 0);
        cycle_pre(); chk("hit_stb", 32'(s_stb_o), 32'b010); cycle_post();
        set_in(1, 0, 0, '0, '0, 0); cycle();
        set_in(1, 0, 0, 3'b010, '0, 0); s_data_i[63:32] = 32'h1234_5678;
        cycle_pre();
        chk("hit_ack",  32'(m_ack_o), 32'd1);
        chk("hit_err",  32'(m_err_o), 32'd0);
        chk("hit_data", m_data_o,     32'h1234_5678);
        cycle_post();
        set_in(1, 0, 0, 3'b010, '0, 0);
        cycle_pre(); chk("hit_drain", 32'(m_ack_o), 32'd0); cycle_post();

        // Decode miss answered by the error slave one cycle later.
        set_in(1, 1, 32'hC000_0004, '0, '0, 0);
        cycle_pre(); chk("miss_stb", 32'(s_stb_o), 32'd0); cycle_post();
        set_in(1, 0, 0, '0, '0, 0);
        cycle_pre();
        chk("miss_ack",  32'(m_ack_o), 32'd1);
        chk("miss_err",  32'(m_err_o), 32'd1);
        chk("miss_data", m_data_o,     ERRD);
        cycle_post();

        // Watchdog: slave 0 never answers.
        set_in(1, 1, 32'h0000_0000, '0, '0, 0); cycle();
        set_in(1, 0, 0, '0, '0, 0);
        repeat (TO) cycle();
        cycle_pre();
        chk("to_ack",  32'(m_ack_o), 32'd1);
        chk("to_err",  32'(m_err_o), 32'd1);
        chk("to_data", m_data_o,     ERRD);
        cycle_post();
        repeat (2) cycle();
        set_in(1, 0, 0, 3'b001, '0, 0);
        cycle_pre();
        chk("late_ack", 32'(m_ack_o),   32'd0);
        chk("to_flag",  32'(timeout_o), 32'd1);
        cycle_post();
        set_in(1, 0, 0, '0, '0, 1); cycle();
        set_in(1, 0, 0, '0, '0, 0);
        cycle_pre(); chk("to_clr", 32'(timeout_o), 32'd0); cycle_post();

        // Abort with two requests outstanding on slave 1.
        set_in(1, 1, 32'h4000_0000, '0, '0, 0); cycle(); cycle();
        set_in(0, 0, 0, '0, '0, 0); cycle();
        set_in(0, 0, 0, 3'b010, '0, 0);
        cycle_pre(); chk("abort_ack", 32'(m_ack_o), 32'd0); cycle_post();

        // Reset in the middle of a burst, then a fresh request to slave 2.
        set_in(1, 1, 32'h4000_0000, '0, '0, 0); cycle(); cycle();
        async_reset();
        set_in(1, 1, 32'h8000_0000, '0, '0, 0);
        cycle_pre(); chk("fresh_stb", 32'(s_stb_o), 32'b100); cycle_post();
        set_in(1, 0, 0, 3'b100, '0, 0);
        cycle_pre(); chk("fresh_ack", 32'(m_ack_o), 32'd1); cycle_post();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
